count_sequencer: RTL
====================

// Module: count_sequencer
// PURPOSE
//  Sequencer/controller for the 4-bit count datapath: start, pause, stop and terminal detection.
//  Latches a programmable limit, advances the count, and reports completion.
//  One-shot or auto-reload operation.
//  Sits between the control/demo logic and the count display;
//  owns the count register and exposes FSM status.
// PARAMETERS
//  WIDTH     4  count and limit width in bits
//  PRESCALE  4  cycles per count step; used only when CNT_SEQ_PRESCALE_EN is defined; must be >=2
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  start      in   1      begin sequence; sampled in IDLE and DONE only
//  stop       in   1      abort to IDLE; highest priority
//  pause      in   1      level; freeze count while high in RUN
//  auto_rld   in   1      1 = wrap to 0 at limit and keep running; 0 = one-shot; latched at start
//  limit      in   WIDTH  terminal count; latched at start
//  count      out  WIDTH  current count
//  busy       out  1      high in RUN or HOLD
//  done       out  1      1-cycle pulse on entry to DONE
//  wrap       out  1      1-cycle pulse on each auto-reload
//  state      out  2      IDLE=00 RUN=01 HOLD=10 DONE=11
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, count=0, lim_q=0, rld_q=0;
//  busy, done and wrap low. Outputs are valid while reset is held.
//  All outputs are registered; no combinational input->output paths.
//  Per-edge priority: stop > pause > start > count step.
//  stop, any state:
//   - next state IDLE, count=0; no done or wrap pulse.
//   - Any pending prescale is discarded.
//  IDLE, start=1:
//   - Latch lim_q=limit and rld_q=auto_rld; count=0.
//   - limit==0 and auto_rld=0: go to DONE, done=1 next cycle.
//   - Otherwise go to RUN.
//  RUN, pause=1: go to HOLD; count not advanced; no terminal check this edge.
//  RUN step, count!=lim_q: count=count+1.
//  RUN step, count==lim_q, rld_q=1: count=0, wrap=1 for one cycle, stay in RUN.
//   - lim_q==0 with rld_q=1 wraps on every step.
//  RUN step, count==lim_q, rld_q=0: go to DONE, done=1 for one cycle, count holds lim_q.
//  HOLD: count frozen; pause=0 returns to RUN. start is ignored.
//  DONE:
//   - count holds lim_q, busy=0.
//   - start=1: relatch inputs and behave as start in IDLE.
//   - Otherwise stay in DONE until start or stop.
//  Latency, one-shot: start edge E gives count=0 after E.
//   - Reaches lim_q after E+lim_q.
//   - DONE with done=1 after E+lim_q+1.
//  Width: count never exceeds lim_q, so no overflow.
//   - lim_q = 2^WIDTH-1 counts the full range.
//  limit, auto_rld: changes are ignored outside the start edge.
//  Reset asserted mid-run: immediate IDLE/zero; start is not remembered.
// CONFIGURATION
//  CNT_SEQ_PRESCALE_EN defined:
//   - An internal divider enables a count step once every PRESCALE cycles in RUN.
//   - The divider clears on start, stop, reset and entry to HOLD.
//   - The first step occurs PRESCALE cycles after start or resume.
//   - done/wrap timing scales with it.
//  CNT_SEQ_PRESCALE_EN undefined:
//   - A count step occurs every RUN cycle.
//   - The PRESCALE parameter is ignored; no divider logic exists.
// TESTING
//  1 Reset mid-RUN (count=5) -> async: count=0, state=00, busy=0, before the next edge.
//  2 limit=3, auto_rld=0, start 1 cycle
//    -> count 0,1,2,3; state=11 and done=1 on the 5th edge; done low after; count stays 3.
//  3 limit=2, auto_rld=1 -> count 0,1,2,0,1,2; wrap pulses exactly once per 0 reload; busy stays 1.
//  4 limit=15, pause at count=7 for 3 cycles -> count stays 7, state=10; resume -> 8 on the next edge.
//  5 stop+start same cycle in RUN, count=4 -> IDLE, count=0, no done.
//    limit=0 one-shot start -> done after 1 edge, count=0.
//  6 With CNT_SEQ_PRESCALE_EN, PRESCALE=4, limit=1, one-shot
//    -> count 0 for 4 cycles, 1 for 4 cycles, then done.
//    Restart from DONE with limit=2 -> fresh sequence.

Source files
------------

// File: rtl/count_sequencer.sv
// -----------------------------------------------------------------------------
// count_sequencer
//   Controller for the count datapath. It owns the count register, latches a
//   programmable terminal count (limit) and the reload mode on start, then
//   advances the count until the terminal value is reached. In one-shot mode it
//   parks in DONE holding the limit. In auto-reload mode it wraps to zero and
//   keeps running.
//
//   State encoding on the state output: IDLE=00 RUN=01 HOLD=10 DONE=11.
//   Per-edge priority: stop > pause > start > count step.
//   All outputs come straight from registers.
//
// Optional feature (macro CNT_SEQ_PRESCALE_EN)
//   When the macro is defined, a divider allows one count step every PRESCALE
//   cycles in RUN. The divider restarts on start, stop, reset and entry to
//   HOLD. When the macro is undefined, the design steps on every RUN cycle,
//   PRESCALE is ignored and no divider logic is built.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high; clears all state
//   start     in   1      begin a sequence (sampled in IDLE and DONE only)
//   stop      in   1      abort to IDLE, highest priority
//   pause     in   1      level; freezes the count while high in RUN
//   auto_rld  in   1      1 = wrap at limit, 0 = one-shot (latched at start)
//   limit     in   WIDTH  terminal count (latched at start)
//   count     out  WIDTH  current count
//   busy      out  1      high in RUN or HOLD
//   done      out  1      one-cycle pulse on entry to DONE
//   wrap      out  1      one-cycle pulse on each auto-reload
//   state     out  2      FSM state (debug/status)
// -----------------------------------------------------------------------------
module count_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_rld,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q,   lim_d;
  logic             rld_q,   rld_d;
  logic             done_q,  done_d;
  logic             wrap_q,  wrap_d;
  logic             busy_q,  busy_d;
  logic             step_en;

`ifdef CNT_SEQ_PRESCALE_EN
  localparam int DIV_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [DIV_W-1:0] div_q, div_d;

  // A step is due when the divider has seen PRESCALE-1 earlier RUN cycles.
  assign step_en = (div_q == DIV_W'(PRESCALE - 1));

  // The divider only advances while RUN is stepping normally. Every other
  // case returns it to zero: stop, start (taken from IDLE/DONE), a pause
  // that enters HOLD, time spent in HOLD, and the step itself.
  always_comb begin
    div_d = '0;
    if (!stop && (state_q == S_RUN) && !pause && !step_en) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  assign step_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            lim_d   = limit;
            rld_d   = auto_rld;
            count_d = '0;
            // A zero-length one-shot has nothing to count: finish at once.
            if ((limit == '0) && !auto_rld) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_HOLD;
          end else if (step_en) begin
            if (count_q != lim_q) begin
              count_d = count_q + 1'b1;
            end else if (rld_q) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      lim_q   <= '0;
      rld_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule
